// File: rtl/lvds_lane_deskew_pkg.sv
// Shared definitions for the multi-lane deskew block.
//   - Default geometry (lane count, symbol width, skew buffer address width)
//   - Default alignment symbol (K28.5) and search timeout
//   - FSM state encoding shared by the top level and anything observing it
package lvds_lane_deskew_pkg;

    localparam int         DEFAULT_LANES           = 4;
    localparam int         DEFAULT_DATA_WIDTH      = 8;
    localparam int         DEFAULT_SKEW_ADDR_WIDTH = 3;
    localparam int         DEFAULT_ALIGN_TIMEOUT   = 64;
    localparam logic [7:0] DEFAULT_ALIGN_SYMBOL    = 8'hBC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_ALIGNED = 2'd2,
        ST_FAIL    = 2'd3
    } deskew_state_e;

endpackage

// File: rtl/lane_deskew_buffer.sv
// Per-lane deskew ring buffer.
// Ports:
//   i_clk, i_arst      clock, async active-high reset
//   i_k_en, i_byte     lane input symbol, written into the ring every cycle
//   i_search           alignment search is active; a matching symbol may be captured
//   i_clear            drop the found flag (takes priority over a capture)
//   i_load             load the read pointer with the marker (current capture included)
//   i_rd_en            advance the read pointer and register the read data
//   o_found            lane has found its marker, including a capture this cycle
//   o_skew             write pointer minus marker, i.e. how far this lane is early
//   o_k_en, o_byte     registered read data
module lane_deskew_buffer
    import lvds_lane_deskew_pkg::*;
#(
    parameter int                    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int                    ADDR_WIDTH   = DEFAULT_SKEW_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] ALIGN_SYMBOL = DEFAULT_ALIGN_SYMBOL
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_k_en,
    input  logic [DATA_WIDTH-1:0] i_byte,
    input  logic                  i_search,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic                  i_rd_en,
    output logic                  o_found,
    output logic [ADDR_WIDTH-1:0] o_skew,
    output logic                  o_k_en,
    output logic [DATA_WIDTH-1:0] o_byte
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH:0]   r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_marker;
    logic                  r_found;
    logic                  r_k_en;
    logic [DATA_WIDTH-1:0] r_byte;

    logic                  w_capture;
    logic [ADDR_WIDTH-1:0] w_marker;

    // Only the first alignment symbol after a clear is captured; later ones are ignored.
    assign w_capture = i_search && !r_found && i_k_en && (i_byte == ALIGN_SYMBOL);
    // A capture this cycle is visible immediately so simultaneous finds complete at once.
    assign w_marker  = w_capture ? r_wr_ptr : r_marker;
    assign o_found   = r_found || w_capture;
    assign o_skew    = r_wr_ptr - w_marker;
    assign o_k_en    = r_k_en;
    assign o_byte    = r_byte;

    // Storage array carries no reset; every location is written before it is read.
    always_ff @(posedge i_clk) begin
        r_mem[r_wr_ptr] <= {i_k_en, i_byte};
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_marker <= '0;
            r_found  <= 1'b0;
            r_k_en   <= 1'b0;
            r_byte   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + 1'b1;

            if (i_clear) begin
                r_found <= 1'b0;
            end else if (w_capture) begin
                r_found  <= 1'b1;
                r_marker <= r_wr_ptr;
            end

            if (i_load) begin
                r_rd_ptr <= w_marker;
            end else if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (i_rd_en) begin
                {r_k_en, r_byte} <= r_mem[r_rd_ptr];
            end
        end
    end

endmodule

// File: rtl/lvds_lane_deskew.sv
// Multi-lane deskew: finds a common alignment K-symbol on every lane, delays the
// early lanes through per-lane ring buffers and emits lane-aligned symbol words.
// Ports:
//   i_clk, i_arst        clock, async active-high reset
//   i_align_start        pulse: start or restart the alignment search
//   i_lane_k_en/byte     per-lane input symbols, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_k_en/o_byte        aligned symbols, same packing
//   o_valid              outputs carry aligned data
//   o_aligned            FSM is in ALIGNED
//   o_align_fail         search timed out (sticky until the next start)
//   o_lane_skew          per-lane delay applied at the last successful alignment
// Handshake: no backpressure; o_k_en/o_byte are meaningful exactly when o_valid is 1.
module lvds_lane_deskew
    import lvds_lane_deskew_pkg::*;
#(
    parameter int                    LANES           = DEFAULT_LANES,
    parameter int                    DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int                    SKEW_ADDR_WIDTH = DEFAULT_SKEW_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] ALIGN_SYMBOL    = DEFAULT_ALIGN_SYMBOL,
    parameter int                    ALIGN_TIMEOUT   = DEFAULT_ALIGN_TIMEOUT
) (
    input  logic                             i_clk,
    input  logic                             i_arst,
    input  logic                             i_align_start,
    input  logic [LANES-1:0]                 i_lane_k_en,
    input  logic [LANES*DATA_WIDTH-1:0]      i_lane_byte,
    output logic [LANES-1:0]                 o_k_en,
    output logic [LANES*DATA_WIDTH-1:0]      o_byte,
    output logic                             o_valid,
    output logic                             o_aligned,
    output logic                             o_align_fail,
    output logic [LANES*SKEW_ADDR_WIDTH-1:0] o_lane_skew
);

    localparam int MAX_SKEW = (1 << SKEW_ADDR_WIDTH) - 2;
    localparam int TO_W     = $clog2(ALIGN_TIMEOUT + 1);

    deskew_state_e                    r_state;
    deskew_state_e                    w_state_nx;
    logic [SKEW_ADDR_WIDTH-1:0]       r_skew_cnt;
    logic [TO_W-1:0]                  r_timeout_cnt;
    logic                             r_valid;
    logic                             r_aligned;
    logic                             r_fail;
    logic [LANES*SKEW_ADDR_WIDTH-1:0] r_lane_skew;

    logic [LANES-1:0]                 w_found;
    logic [LANES-1:0]                 w_is_sym;
    logic [LANES*SKEW_ADDR_WIDTH-1:0] w_skew;
    logic                             w_search;
    logic                             w_rd_en;
    logic                             w_all_found;
    logic                             w_any_found;
    logic                             w_timeout;
    logic                             w_mismatch;
    logic                             w_retry;
    logic                             w_clear;
    logic                             w_load;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_deskew_buffer #(
            .DATA_WIDTH   (DATA_WIDTH),
            .ADDR_WIDTH   (SKEW_ADDR_WIDTH),
            .ALIGN_SYMBOL (ALIGN_SYMBOL)
        ) u_buf (
            .i_clk    (i_clk),
            .i_arst   (i_arst),
            .i_k_en   (i_lane_k_en[g]),
            .i_byte   (i_lane_byte[g*DATA_WIDTH +: DATA_WIDTH]),
            .i_search (w_search),
            .i_clear  (w_clear),
            .i_load   (w_load),
            .i_rd_en  (w_rd_en),
            .o_found  (w_found[g]),
            .o_skew   (w_skew[g*SKEW_ADDR_WIDTH +: SKEW_ADDR_WIDTH]),
            .o_k_en   (o_k_en[g]),
            .o_byte   (o_byte[g*DATA_WIDTH +: DATA_WIDTH])
        );

        assign w_is_sym[g] = o_k_en[g] && (o_byte[g*DATA_WIDTH +: DATA_WIDTH] == ALIGN_SYMBOL);
    end

    assign w_search    = (r_state == ST_SEARCH);
    assign w_rd_en     = (r_state == ST_ALIGNED);
    assign w_all_found = &w_found;
    assign w_any_found = |w_found;
    assign w_timeout   = (r_timeout_cnt == TO_W'(ALIGN_TIMEOUT - 1));
    // Lanes disagree on the alignment symbol: only meaningful while data is valid.
    assign w_mismatch  = r_valid && (|w_is_sym) && !(&w_is_sym);
    // skew_cnt == MAX_SKEW means the next cycle would exceed the tolerated skew.
    assign w_retry     = w_search && !i_align_start && !w_all_found &&
                         (r_skew_cnt == SKEW_ADDR_WIDTH'(MAX_SKEW));
    // Found flags only survive inside an uninterrupted search.
    assign w_clear     = !w_search || i_align_start || w_retry;

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        if (i_align_start) begin
            w_state_nx = ST_SEARCH;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_nx = ST_IDLE;
                ST_SEARCH: begin
                    if (w_all_found) begin
                        w_state_nx = ST_ALIGNED;
                        w_load     = 1'b1;
                    end else if (w_timeout) begin
                        w_state_nx = ST_FAIL;
                    end
                end
                ST_ALIGNED: if (w_mismatch) w_state_nx = ST_SEARCH;
                ST_FAIL:    w_state_nx = ST_FAIL;
                default:    w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state       <= ST_IDLE;
            r_skew_cnt    <= '0;
            r_timeout_cnt <= '0;
            r_valid       <= 1'b0;
            r_aligned     <= 1'b0;
            r_fail        <= 1'b0;
            r_lane_skew   <= '0;
        end else begin
            r_state <= w_state_nx;

            if (w_clear) begin
                r_skew_cnt <= '0;
            end else if (w_any_found) begin
                r_skew_cnt <= r_skew_cnt + 1'b1;
            end

            if (w_search && !i_align_start) begin
                r_timeout_cnt <= r_timeout_cnt + 1'b1;
            end else begin
                r_timeout_cnt <= '0;
            end

            // First ALIGNED cycle reads the marker; its data is valid one cycle later.
            r_valid   <= (r_state == ST_ALIGNED) && (w_state_nx == ST_ALIGNED);
            r_aligned <= (w_state_nx == ST_ALIGNED);
            r_fail    <= (w_state_nx == ST_FAIL);

            if (w_load) begin
                r_lane_skew <= w_skew;
            end
        end
    end

    assign o_valid      = r_valid;
    assign o_aligned    = r_aligned;
    assign o_align_fail = r_fail;
    assign o_lane_skew  = r_lane_skew;

endmodule

// File: tb/tb_lvds_lane_deskew.sv
module tb_lvds_lane_deskew;

    localparam int         LANES   = 4;
    localparam int         DW      = 8;
    localparam int         SAW     = 3;
    localparam int         TIMEOUT = 64;
    localparam int         PERIOD  = 32;
    localparam int         NCYC    = 4096;
    localparam logic [7:0] BC      = 8'hBC;

    logic                 i_clk = 1'b0;
    logic                 i_arst;
    logic                 i_align_start;
    logic [LANES-1:0]     i_lane_k_en;
    logic [LANES*DW-1:0]  i_lane_byte;
    logic [LANES-1:0]     o_k_en;
    logic [LANES*DW-1:0]  o_byte;
    logic                 o_valid;
    logic                 o_aligned;
    logic                 o_align_fail;
    logic [LANES*SAW-1:0] o_lane_skew;

    // Each lane has its own symbol stream; K28.5 lands on the same source cycle in all.
    logic [DW:0] src [LANES][NCYC];
    int          d [LANES];
    int          cyc;
    int          phase;
    bit          chk_en;
    bit          start_req;
    int          n_cmp;
    int          n_bad;

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: cycle %0d reached, required finish earlier", cyc);
        $fatal(1);
    end

    lvds_lane_deskew #(
        .LANES           (LANES),
        .DATA_WIDTH      (DW),
        .SKEW_ADDR_WIDTH (SAW),
        .ALIGN_SYMBOL    (BC),
        .ALIGN_TIMEOUT   (TIMEOUT)
    ) dut (
        .i_clk         (i_clk),
        .i_arst        (i_arst),
        .i_align_start (i_align_start),
        .i_lane_k_en   (i_lane_k_en),
        .i_lane_byte   (i_lane_byte),
        .o_k_en        (o_k_en),
        .o_byte        (o_byte),
        .o_valid       (o_valid),
        .o_aligned     (o_aligned),
        .o_align_fail  (o_align_fail),
        .o_lane_skew   (o_lane_skew)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int dmax_f();
        int m = 0;
        for (int i = 0; i < LANES; i++) if (d[i] > m) m = d[i];
        return m;
    endfunction

    function automatic int dmin_f();
        int m = d[0];
        for (int i = 1; i < LANES; i++) if (d[i] < m) m = d[i];
        return m;
    endfunction

    // Each lane is delayed so that it lines up with the latest lane.
    function automatic logic [LANES*SAW-1:0] exp_skew_f();
        logic [LANES*SAW-1:0] v = '0;
        for (int i = 0; i < LANES; i++) v[i*SAW +: SAW] = SAW'(dmax_f() - d[i]);
        return v;
    endfunction

    // Start driven in cycle s => search from s+1. The first marker group whose earliest
    // lane arrives inside the search completes when its latest lane arrives (cycle T);
    // the aligned marker shows on the outputs at T+2.
    function automatic int exp_valid_cycle(input int s);
        int t0;
        for (int k = 0; k < 200; k++) begin
            t0 = phase + PERIOD * k;
            if (t0 + dmin_f() >= s + 1) return t0 + dmax_f() + 2;
        end
        return -1;
    endfunction

    // ---------------- driver ----------------
    task automatic tick();
        logic [LANES-1:0]    k;
        logic [LANES*DW-1:0] b;
        int                  t;
        int                  u;
        @(posedge i_clk);
        #1;
        cyc++;
        for (int i = 0; i < LANES; i++) begin
            t = cyc - d[i];
            if (t >= 0 && t < NCYC) begin
                {k[i], b[i*DW +: DW]} = src[i][t];
            end else begin
                k[i]          = 1'b0;
                b[i*DW +: DW] = '0;
            end
        end
        i_lane_k_en   = k;
        i_lane_byte   = b;
        i_align_start = start_req;
        start_req     = 1'b0;
        // Aligned output in cycle t is the source symbol of cycle t-2-dmax on every lane.
        if (chk_en && o_valid) begin
            u = cyc - 2 - dmax_f();
            if (u >= 0) begin
                for (int i = 0; i < LANES; i++) begin
                    check($sformatf("data_l%0d", i), 64'({o_k_en[i], o_byte[i*DW +: DW]}),
                          64'(src[i][u]));
                end
            end
        end
    endtask

    task automatic do_align(input string name);
        int                  s;
        int                  rise;
        logic [LANES*DW-1:0] all_bc;
        chk_en    = 1'b0;
        start_req = 1'b1;
        tick();
        s = cyc;
        tick();
        check({name, "_fail_clr"}, 64'(o_align_fail), 64'(0));
        check({name, "_valid_drop"}, 64'(o_valid), 64'(0));
        rise = -1;
        for (int n = 0; n < 300 && rise < 0; n++) begin
            tick();
            if (o_valid) rise = cyc;
        end
        check({name, "_valid_rise"}, 64'(rise), 64'(exp_valid_cycle(s)));
        if (rise >= 0) begin
            all_bc = {LANES{BC}};
            check({name, "_aligned"}, 64'(o_aligned), 64'(1));
            check({name, "_bc_k"}, 64'(o_k_en), 64'({LANES{1'b1}}));
            check({name, "_bc_byte"}, 64'(o_byte), 64'(all_bc));
            check({name, "_skew"}, 64'(o_lane_skew), 64'(exp_skew_f()));
            chk_en = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b;
        int s;
        int fail_at;
        int bad;
        int rise;

        n_cmp = 0; n_bad = 0; cyc = 0; chk_en = 1'b0; start_req = 1'b0;
        phase = $urandom_range(0, PERIOD - 1);
        for (int t = 0; t < NCYC; t++) begin
            for (int i = 0; i < LANES; i++) begin
                if (t % PERIOD == phase) begin
                    src[i][t] = {1'b1, BC};
                end else if ($urandom_range(0, 15) == 0) begin
                    src[i][t] = {1'b1, 8'h1C};
                end else begin
                    src[i][t] = {1'b0, 8'($urandom_range(0, 255))};
                end
            end
        end
        for (int i = 0; i < LANES; i++) d[i] = 0;

        i_arst = 1'b1; i_align_start = 1'b0; i_lane_k_en = '0; i_lane_byte = '0;
        repeat (3) tick();
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_aligned", 64'(o_aligned), 64'(0));
        check("rst_fail", 64'(o_align_fail), 64'(0));
        check("rst_skew", 64'(o_lane_skew), 64'(0));
        check("rst_data", 64'({o_k_en, o_byte}), 64'(0));
        i_arst = 1'b0;
        repeat (40) tick();
        check("idle_no_start", 64'({o_aligned, o_valid, o_align_fail}), 64'(0));

        // zero skew
        do_align("zero");
        repeat (40) tick();

        // lanes delayed 0,1,3,5
        d[0] = 0; d[1] = 1; d[2] = 3; d[3] = 5;
        do_align("skew");
        check("skew_const", 64'(o_lane_skew), 64'({3'd0, 3'd2, 3'd4, 3'd5}));
        repeat (40) tick();

        // random skews within tolerance
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < LANES; i++) d[i] = $urandom_range(0, 6);
            do_align($sformatf("rand%0d", r));
            repeat (40) tick();
        end

        // one-cycle slip on lane1 while aligned
        d[0] = 0; d[1] = 1; d[2] = 3; d[3] = 5;
        do_align("pre_slip");
        b = -1;
        for (int n = 0; n < 64 && b < 0; n++) begin
            tick();
            if (o_valid && o_k_en[0] && o_byte[DW-1:0] == BC) b = cyc;
        end
        check("slip_bc_seen", 64'(b >= 0), 64'(1));
        chk_en = 1'b0;
        d[1]   = 2;
        while (cyc < b + PERIOD) tick();
        check("slip_valid_hold", 64'(o_valid), 64'(1));
        tick();
        check("slip_valid_fall", 64'(o_valid), 64'(0));
        check("slip_aligned_fall", 64'(o_aligned), 64'(0));
        rise = -1;
        for (int n = 0; n < 300 && rise < 0; n++) begin
            tick();
            if (o_valid) rise = cyc;
        end
        check("slip_realign", 64'(rise), 64'(exp_valid_cycle(b + PERIOD)));
        check("slip_skew", 64'(o_lane_skew), 64'(exp_skew_f()));
        check("slip_skew_l1", 64'(o_lane_skew[SAW +: SAW]), 64'(3));
        chk_en = 1'b1;
        repeat (40) tick();

        // asynchronous reset while aligned
        chk_en = 1'b0;
        #2 i_arst = 1'b1;
        #1;
        check("arst_valid", 64'(o_valid), 64'(0));
        check("arst_aligned", 64'(o_aligned), 64'(0));
        check("arst_skew", 64'(o_lane_skew), 64'(0));
        check("arst_data", 64'({o_k_en, o_byte}), 64'(0));
        tick();
        tick();
        i_arst = 1'b0;
        bad = 0;
        repeat (100) begin
            tick();
            if (o_aligned || o_valid || o_align_fail || o_lane_skew != '0) bad++;
        end
        check("idle_100", 64'(bad), 64'(0));

        // lane2 beyond tolerated skew: retries until timeout
        d[0] = 0; d[1] = 0; d[2] = 7; d[3] = 0;
        start_req = 1'b1;
        tick();
        s       = cyc;
        fail_at = -1;
        bad     = 0;
        for (int n = 0; n < 150 && fail_at < 0; n++) begin
            tick();
            if (o_valid || o_aligned) bad++;
            if (o_align_fail) fail_at = cyc;
        end
        check("fail_time", 64'(fail_at), 64'(s + 1 + TIMEOUT));
        check("fail_no_align", 64'(bad), 64'(0));
        repeat (10) tick();
        check("fail_sticky", 64'(o_align_fail), 64'(1));
        check("fail_valid", 64'({o_valid, o_aligned}), 64'(0));

        // recover from FAIL
        d[2] = 3;
        do_align("recover");
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
